// File: rtl/spi_slave_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_regs_if
// Description : Bundle of the SPI pins, the host preload port and the access
//               report outputs of spi_slave_regs.
//               slave  modport : seen by the responder (spi_slave_regs)
//               master modport : seen by the SPI master / host side
//               Optional SPI_SLAVE_FRAME_ERR_EN adds the frame_err signal.
// Ports       : sclk, cs, mosi, miso           - SPI link (mode 0, cs low)
//               ld_en, ld_addr, ld_data        - host preload
//               wr_vld, rd_vld                 - access completion pulses
//               acc_addr, acc_data             - last committed access
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_regs_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic                  ld_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  wr_vld;
  logic                  rd_vld;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                  frame_err;

  modport slave (
    input  sclk, cs, mosi, ld_en, ld_addr, ld_data,
    output miso, wr_vld, rd_vld, acc_addr, acc_data, frame_err
  );

  modport master (
    output sclk, cs, mosi, ld_en, ld_addr, ld_data,
    input  miso, wr_vld, rd_vld, acc_addr, acc_data, frame_err
  );
`else
  modport slave (
    input  sclk, cs, mosi, ld_en, ld_addr, ld_data,
    output miso, wr_vld, rd_vld, acc_addr, acc_data
  );

  modport master (
    output sclk, cs, mosi, ld_en, ld_addr, ld_data,
    input  miso, wr_vld, rd_vld, acc_addr, acc_data
  );
`endif
endinterface
`default_nettype wire

// File: rtl/spi_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_regs
// Description : SPI mode-0 responder terminating 1+ADDR_WIDTH+DATA_WIDTH bit
//               command frames (R/W, address, data; MSB first) against an
//               internal bank of 2^ADDR_WIDTH x DATA_WIDTH registers that the
//               local host can also preload. sclk/cs/mosi are oversampled in
//               the clk domain through 2-FF synchronizers.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               bus    - spi_slave_regs_if.slave (SPI pins, preload port,
//                        wr_vld/rd_vld pulses, acc_addr/acc_data report)
// Options     : SPI_SLAVE_FRAME_ERR_EN - adds bus.frame_err, a one-cycle
//               pulse when a frame is aborted by cs rising mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_regs #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input wire logic        clk,
  input wire logic        rst_n,
  spi_slave_regs_if.slave bus
);

  localparam int C_HDR_LEN   = 1 + ADDR_WIDTH;
  localparam int C_FRAME_LEN = C_HDR_LEN + DATA_WIDTH;
  localparam int C_CNT_W     = $clog2(C_FRAME_LEN);
  localparam int C_DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [C_CNT_W-1:0] C_HDR_LAST   = C_CNT_W'(C_HDR_LEN - 1);
  localparam logic [C_CNT_W-1:0] C_FRAME_LAST = C_CNT_W'(C_FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_WR      = 3'd2,
    S_RD      = 3'd3,
    S_WAIT_CS = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Synchronizers: bits [1:0] are the 2-FF chain, bit [2] is the one-cycle
  // delayed synchronized value used for edge detection.
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  logic [C_CNT_W-1:0]    bit_cnt_q;
  logic [DATA_WIDTH-2:0] rx_q;      // previously received bits; current bit comes from mosi_s
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic                  miso_q;
  logic                  wr_vld_q;
  logic                  rd_vld_q;
  logic [ADDR_WIDTH-1:0] acc_addr_q;
  logic [DATA_WIDTH-1:0] acc_data_q;
  logic [DATA_WIDTH-1:0] regs_q [C_DEPTH];

  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  logic                  hdr_done, wr_commit, rd_done;
  logic [C_HDR_LEN-1:0]  hdr_word;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [DATA_WIDTH-1:0] data_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.sclk};
      cs_q   <= {cs_q[1:0], bus.cs};
      mosi_q <= {mosi_q[0], bus.mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign mosi_s    = mosi_q[1];

  // Words as they stand once the bit on the current rising edge is included.
  assign hdr_word  = {rx_q[C_HDR_LEN-2:0], mosi_s};
  assign hdr_addr  = hdr_word[ADDR_WIDTH-1:0];
  assign data_word = {rx_q, mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    hdr_done  = 1'b0;
    wr_commit = 1'b0;
    rd_done   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cs_fall) state_d = S_HDR;
      end
      S_HDR: begin
        if (cs_rise) begin
          state_d = S_IDLE;
        end else if (sclk_rise && bit_cnt_q == C_HDR_LAST) begin
          hdr_done = 1'b1;
          state_d  = hdr_word[C_HDR_LEN-1] ? S_RD : S_WR;
        end
      end
      S_WR: begin
        if (cs_rise) begin
          state_d = S_IDLE;
        end else if (sclk_rise && bit_cnt_q == C_FRAME_LAST) begin
          wr_commit = 1'b1;
          state_d   = S_WAIT_CS;
        end
      end
      S_RD: begin
        if (cs_rise) begin
          state_d = S_IDLE;
        end else if (sclk_rise && bit_cnt_q == C_FRAME_LAST) begin
          rd_done = 1'b1;
          state_d = S_WAIT_CS;
        end
      end
      S_WAIT_CS: begin
        if (cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      wr_vld_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      acc_addr_q <= '0;
      acc_data_q <= '0;
    end else begin
      wr_vld_q <= wr_commit;
      rd_vld_q <= rd_done;

      if (state_q == S_IDLE)
        bit_cnt_q <= '0;
      else if (sclk_rise && state_q != S_WAIT_CS)
        bit_cnt_q <= bit_cnt_q + C_CNT_W'(1);

      if (sclk_rise) rx_q <= data_word[DATA_WIDTH-2:0];

      // The read value is frozen here, so later preloads cannot alter it.
      if (hdr_done) begin
        addr_q <= hdr_addr;
        tx_q   <= regs_q[hdr_addr];
      end

      // tx_q rotates rather than shifts: a complete read sees exactly
      // DATA_WIDTH falling edges, leaving tx_q holding the returned value.
      if (state_q == S_RD && sclk_fall) begin
        miso_q <= tx_q[DATA_WIDTH-1];
        tx_q   <= {tx_q[DATA_WIDTH-2:0], tx_q[DATA_WIDTH-1]};
      end else if (state_q == S_IDLE) begin
        miso_q <= 1'b0;
      end

      if (wr_commit) begin
        acc_addr_q <= addr_q;
        acc_data_q <= data_word;
      end else if (rd_done) begin
        acc_addr_q <= addr_q;
        acc_data_q <= tx_q;
      end
    end
  end

  // Register bank; the SPI write is assigned last so it wins over a
  // same-cycle preload to the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_DEPTH; i++) regs_q[i] <= '0;
    end else begin
      if (bus.ld_en) regs_q[bus.ld_addr] <= bus.ld_data;
      if (wr_commit) regs_q[addr_q] <= data_word;
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= cs_rise &&
                               (state_q == S_HDR || state_q == S_WR || state_q == S_RD);
  end

  assign bus.frame_err = frame_err_q;
`endif

  // miso is forced low whenever the master deselects us.
  assign bus.miso     = miso_q & ~bus.cs;
  assign bus.wr_vld   = wr_vld_q;
  assign bus.rd_vld   = rd_vld_q;
  assign bus.acc_addr = acc_addr_q;
  assign bus.acc_data = acc_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_regs
// Description : Self-checking bench for spi_slave_regs. Acts as SPI master
//               and host, keeps a plain array model of the register bank and
//               compares read data, access reports and pulse counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_regs;

  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int HALF = 8;   // sclk half period in clk cycles

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spi_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int fe_cnt = 0;
  logic [DW-1:0] model [1 << AW];

  always @(negedge clk) begin
    if (bus.wr_vld === 1'b1) wr_cnt++;
    if (bus.rd_vld === 1'b1) rd_cnt++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (bus.frame_err === 1'b1) fe_cnt++;
`endif
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits of frame, then extra sclk pulses, then optionally
  // raises cs. rx collects miso sampled at rising sclk for bits 4..11.
  // collide: issue a preload of 0x11 to addr 2 in the cycle of write commit.
  task automatic spi_xfer(input logic [11:0] frame, input int nbits, input int extra,
                          input bit collide, input bit raise_cs, output logic [7:0] rx);
    rx = '0;
    bus.cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = frame[11-i];
      wait_clk(HALF);
      bus.sclk = 1'b1;
      if (i >= 4) rx = {rx[6:0], bus.miso};
      if (collide && i == 11) begin
        wait_clk(2);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 3'd2;
        bus.ld_data = 8'h11;
        wait_clk(1);
        bus.ld_en = 1'b0;
        tests++;
        if (bus.wr_vld !== 1'b1) begin
          fails++;
          $display("FAIL collide_latency: wr_vld=%b required 1", bus.wr_vld);
        end
        wait_clk(HALF - 3);
      end else begin
        wait_clk(HALF);
      end
      bus.sclk = 1'b0;
    end
    for (int i = 0; i < extra; i++) begin
      bus.mosi = 1'($urandom);
      wait_clk(HALF);
      bus.sclk = 1'b1;
      wait_clk(HALF);
      bus.sclk = 1'b0;
    end
    if (raise_cs) begin
      wait_clk(HALF);
      bus.cs = 1'b1;
      wait_clk(10);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    wait_clk(1);
    bus.ld_en = 1'b0;
    wait_clk(1);
    model[a] = d;
  endtask

  task automatic test_reset();
    logic [7:0] rx;
    int r0;
    bus.sclk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    for (int i = 0; i < (1 << AW); i++) model[i] = '0;
    rst_n = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(3);
    tests++; if (bus.miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b required 0", bus.miso); end
    tests++; if (bus.wr_vld !== 1'b0) begin fails++; $display("FAIL reset_wr_vld: got %b required 0", bus.wr_vld); end
    tests++; if (bus.rd_vld !== 1'b0) begin fails++; $display("FAIL reset_rd_vld: got %b required 0", bus.rd_vld); end
    tests++; if (bus.acc_addr !== 3'd0) begin fails++; $display("FAIL reset_acc_addr: got %h required 0", bus.acc_addr); end
    tests++; if (bus.acc_data !== 8'h00) begin fails++; $display("FAIL reset_acc_data: got %h required 00", bus.acc_data); end
    r0 = rd_cnt;
    spi_xfer(12'hF00, 12, 0, 1'b0, 1'b1, rx);
    tests++; if (rx !== model[7]) begin fails++; $display("FAIL reset_reg7: got %h required %h", rx, model[7]); end
    tests++; if (rd_cnt - r0 !== 1) begin fails++; $display("FAIL reset_rd_pulses: got %0d required 1", rd_cnt - r0); end
  endtask

  task automatic test_write_read();
    logic [7:0] rx;
    int w0, r0;
    w0 = wr_cnt;
    spi_xfer(12'h3A5, 12, 0, 1'b0, 1'b1, rx);
    model[3] = 8'hA5;
    tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL wr_pulses: got %0d required 1", wr_cnt - w0); end
    tests++; if (bus.acc_addr !== 3'd3) begin fails++; $display("FAIL wr_acc_addr: got %h required 3", bus.acc_addr); end
    tests++; if (bus.acc_data !== 8'hA5) begin fails++; $display("FAIL wr_acc_data: got %h required a5", bus.acc_data); end
    r0 = rd_cnt;
    spi_xfer(12'hB00, 12, 0, 1'b0, 1'b1, rx);
    tests++; if (rx !== model[3]) begin fails++; $display("FAIL rd_miso: got %h required %h", rx, model[3]); end
    tests++; if (rd_cnt - r0 !== 1) begin fails++; $display("FAIL rd_pulses: got %0d required 1", rd_cnt - r0); end
    tests++; if (bus.acc_data !== model[3]) begin fails++; $display("FAIL rd_acc_data: got %h required %h", bus.acc_data, model[3]); end
    tests++; if (bus.miso !== 1'b0) begin fails++; $display("FAIL miso_cs_high: got %b required 0", bus.miso); end
  endtask

  task automatic test_preload();
    logic [7:0] rx;
    int r0;
    preload(3'd5, 8'hC3);
    r0 = rd_cnt;
    spi_xfer(12'hD00, 12, 0, 1'b0, 1'b1, rx);
    tests++; if (rx !== 8'hC3) begin fails++; $display("FAIL preload_miso: got %h required c3", rx); end
    tests++; if (rd_cnt - r0 !== 1) begin fails++; $display("FAIL preload_rd_pulses: got %0d required 1", rd_cnt - r0); end
    tests++; if (bus.acc_data !== 8'hC3) begin fails++; $display("FAIL preload_acc_data: got %h required c3", bus.acc_data); end
    tests++; if (bus.acc_addr !== 3'd5) begin fails++; $display("FAIL preload_acc_addr: got %h required 5", bus.acc_addr); end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int w0, r0, f0;
    w0 = wr_cnt; r0 = rd_cnt; f0 = fe_cnt;
    spi_xfer({1'b0, 3'd6, 8'h5A}, 7, 0, 1'b0, 1'b1, rx);   // aborted in data phase
    spi_xfer({1'b0, 3'd6, 8'h3C}, 2, 0, 1'b0, 1'b1, rx);   // aborted in header
    spi_xfer({1'b1, 3'd5, 8'h00}, 8, 0, 1'b0, 1'b1, rx);   // aborted read
    tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL abort_wr_pulses: got %0d required 0", wr_cnt - w0); end
    tests++; if (rd_cnt - r0 !== 0) begin fails++; $display("FAIL abort_rd_pulses: got %0d required 0", rd_cnt - r0); end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    tests++; if (fe_cnt - f0 !== 3) begin fails++; $display("FAIL abort_frame_err: got %0d required 3", fe_cnt - f0); end
`endif
    spi_xfer(12'hE00, 12, 0, 1'b0, 1'b1, rx);
    tests++; if (rx !== model[6]) begin fails++; $display("FAIL abort_reg6: got %h required %h", rx, model[6]); end
  endtask

  task automatic test_extra_sclk();
    logic [7:0] rx;
    logic [7:0] d;
    int w0;
    d  = 8'($urandom);
    w0 = wr_cnt;
    spi_xfer({1'b0, 3'd1, d}, 12, 4, 1'b0, 1'b1, rx);
    model[1] = d;
    tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL extra_wr_pulses: got %0d required 1", wr_cnt - w0); end
    spi_xfer(12'h900, 12, 0, 1'b0, 1'b1, rx);
    tests++; if (rx !== model[1]) begin fails++; $display("FAIL extra_reg1: got %h required %h", rx, model[1]); end
  endtask

  task automatic test_collision();
    logic [7:0] rx;
    spi_xfer({1'b0, 3'd2, 8'h22}, 12, 0, 1'b1, 1'b1, rx);
    model[2] = 8'h22;   // SPI write has priority over the same-cycle preload
    spi_xfer(12'hA00, 12, 0, 1'b0, 1'b1, rx);
    tests++; if (rx !== model[2]) begin fails++; $display("FAIL collision_reg2: got %h required %h", rx, model[2]); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    int r0;
    preload(3'd4, 8'hFF);
    spi_xfer(12'hC00, 6, 0, 1'b0, 1'b0, rx);
    wait_clk(5);
    tests++; if (bus.miso !== 1'b1) begin fails++; $display("FAIL midrd_miso_active: got %b required 1", bus.miso); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.miso !== 1'b0) begin fails++; $display("FAIL midrd_miso_reset: got %b required 0", bus.miso); end
    for (int i = 0; i < (1 << AW); i++) model[i] = '0;
    bus.cs = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    tests++; if (bus.acc_data !== 8'h00) begin fails++; $display("FAIL midrd_acc_data: got %h required 00", bus.acc_data); end
    r0 = rd_cnt;
    spi_xfer(12'hC00, 12, 0, 1'b0, 1'b1, rx);
    tests++; if (rx !== model[4]) begin fails++; $display("FAIL midrd_reg4: got %h required %h", rx, model[4]); end
    tests++; if (rd_cnt - r0 !== 1) begin fails++; $display("FAIL midrd_rd_pulses: got %0d required 1", rd_cnt - r0); end
  endtask

  task automatic test_random();
    logic [7:0] rx;
    logic [2:0] a;
    logic [7:0] d;
    int op, w0, r0;
    for (int n = 0; n < 24; n++) begin
      op = $urandom_range(0, 2);
      a  = 3'($urandom);
      d  = 8'($urandom);
      if (op == 0) begin
        w0 = wr_cnt;
        spi_xfer({1'b0, a, d}, 12, 0, 1'b0, 1'b1, rx);
        model[a] = d;
        tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL rand_wr_pulses: got %0d required 1", wr_cnt - w0); end
        tests++; if (bus.acc_addr !== a || bus.acc_data !== d) begin
          fails++; $display("FAIL rand_wr_acc: got %h/%h required %h/%h", bus.acc_addr, bus.acc_data, a, d);
        end
      end else if (op == 1) begin
        r0 = rd_cnt;
        spi_xfer({1'b1, a, d}, 12, 0, 1'b0, 1'b1, rx);
        tests++; if (rx !== model[a]) begin fails++; $display("FAIL rand_rd_miso: addr %0d got %h required %h", a, rx, model[a]); end
        tests++; if (rd_cnt - r0 !== 1) begin fails++; $display("FAIL rand_rd_pulses: got %0d required 1", rd_cnt - r0); end
        tests++; if (bus.acc_addr !== a || bus.acc_data !== model[a]) begin
          fails++; $display("FAIL rand_rd_acc: got %h/%h required %h/%h", bus.acc_addr, bus.acc_data, a, model[a]);
        end
      end else begin
        preload(a, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_preload();
    test_abort();
    test_extra_sclk();
    test_collision();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
